// File: rtl/pid_pkg.sv
// pid_pkg: constants and helpers shared by the parametrised PID heading controller.
//   - default width constants for pid_ctrl_param and pid_deriv
//   - legacy gain values (KP_LEGACY / KD_LEGACY) that reproduce the fixed-gain scaling
//   - sat_signed(): signed saturation from an arbitrary input width to an output width
package pid_pkg;

    localparam int ERR_W_DEF   = 12;
    localparam int SAT_W_DEF   = 10;
    localparam int FRWRD_W_DEF = 10;
    localparam int SPD_W_DEF   = 11;
    localparam int INT_W_DEF   = 15;
    localparam int I_SHIFT_DEF = 6;
    localparam int D_DEPTH_DEF = 3;
    localparam int PID_W_DEF   = 14;

    // Gains are 5-bit unsigned.
    localparam int GAIN_W = 5;

    localparam int KP_LEGACY = 8;
    localparam int KD_LEGACY = 7;

    // Saturate a signed value to out_w bits. Only the low in_w bits of val are
    // meaningful; they are sign-extended first, so callers may pass a value that
    // was zero- or sign-extended to 32 bits. Result is sign-extended to 32 bits;
    // callers size-cast it down to out_w. Widths must satisfy 1 < out_w < 32.
    function automatic logic signed [31:0] sat_signed(
        input logic signed [31:0] val,
        input int                 in_w,
        input int                 out_w
    );
        logic signed [31:0] v;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        v  = (val <<< (32 - in_w)) >>> (32 - in_w);
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/pid_deriv.sv
// pid_deriv: derivative term of the PID controller.
//   Keeps a history of the last D_DEPTH valid saturated errors. On each valid
//   sample the difference err_sat - (sample D_DEPTH strobes ago) is saturated to
//   SAT_W-2 bits, multiplied by the unsigned gain kd and registered.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of history and term (robot not moving)
//   en         : sample valid (one cycle per sample)
//   err_sat    : signed saturated error, SAT_W bits
//   kd         : unsigned D gain, sampled when en is high
//   d_term     : registered signed D term, D_W bits
module pid_deriv
    import pid_pkg::*;
#(
    parameter int SAT_W   = SAT_W_DEF,
    parameter int D_DEPTH = D_DEPTH_DEF,
    parameter int D_W     = SAT_W - 2 + GAIN_W + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [SAT_W-1:0] err_sat,
    input  logic [GAIN_W-1:0]       kd,
    output logic signed [D_W-1:0]   d_term
);

    localparam int DIFF_W = SAT_W - 2;

    // hist[0] is the most recent sample, hist[D_DEPTH-1] the oldest.
    logic signed [SAT_W-1:0]  hist [D_DEPTH];
    logic signed [DIFF_W-1:0] diff;
    logic signed [D_W-1:0]    d_prod;

    always_comb begin
        diff   = DIFF_W'(sat_signed(32'(err_sat) - 32'(hist[D_DEPTH-1]), 32, DIFF_W));
        // kd is unsigned: prefix a zero so the signed multiply treats it as positive.
        d_prod = D_W'(diff) * D_W'($signed({1'b0, kd}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < D_DEPTH; k++) begin
                hist[k] <= '0;
            end
            d_term <= '0;
        end else if (clr) begin
            for (int k = 0; k < D_DEPTH; k++) begin
                hist[k] <= '0;
            end
            d_term <= '0;
        end else if (en) begin
            for (int k = D_DEPTH - 1; k > 0; k--) begin
                hist[k] <= hist[k-1];
            end
            hist[0] <= err_sat;
            d_term  <= d_prod;
        end
    end

endmodule

// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param: three-stage pipelined PID heading controller with
// programmable P/D gains, configurable derivative depth, selectable
// integrator anti-windup and saturated left/right wheel speeds.
//
// Strobe semantics: err_vld is a single-cycle qualifier for error with no
// back-pressure; every strobe accepted while moving=1 produces exactly one
// spd_vld pulse three cycles later, in order, one sample per cycle.
// moving=0 discards everything in flight and zeroes outputs and state.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   moving             : 0 clears integrator, derivative history and outputs
//   err_vld, error     : signed heading error and its strobe
//   frwrd              : unsigned forward speed (sampled with the P/I/D terms)
//   kp, kd             : unsigned P and D gains (sampled in the second stage)
//   lft_spd, rght_spd  : saturated signed wheel speeds, held between pulses
//   spd_vld            : one-cycle pulse when the speeds update
module pid_ctrl_param
    import pid_pkg::*;
#(
    parameter int ERR_W     = ERR_W_DEF,
    parameter int SAT_W     = SAT_W_DEF,
    parameter int FRWRD_W   = FRWRD_W_DEF,
    parameter int SPD_W     = SPD_W_DEF,
    parameter int INT_W     = INT_W_DEF,
    parameter int I_SHIFT   = I_SHIFT_DEF,
    parameter int D_DEPTH   = D_DEPTH_DEF,
    parameter int PID_W     = PID_W_DEF,
    parameter int INT_CLAMP = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    moving,
    input  logic                    err_vld,
    input  logic signed [ERR_W-1:0] error,
    input  logic [FRWRD_W-1:0]      frwrd,
    input  logic [GAIN_W-1:0]       kp,
    input  logic [GAIN_W-1:0]       kd,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    spd_vld
);

    localparam int P_W   = SAT_W + GAIN_W + 1;
    localparam int D_W   = SAT_W - 2 + GAIN_W + 1;
    localparam int I_W   = INT_W - I_SHIFT;
    localparam int SUM_W = PID_W + 2;
    localparam int IS_W  = INT_W + 1;

    localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    // ---------------- stage 1: error saturation ----------------
    logic signed [SAT_W-1:0] err_sat_d;
    logic signed [SAT_W-1:0] err_sat;
    logic                    v1;

    always_comb begin
        err_sat_d = SAT_W'(sat_signed(32'(error), ERR_W, SAT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sat <= '0;
            v1      <= 1'b0;
        end else if (!moving) begin
            err_sat <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= err_vld;
            if (err_vld) begin
                err_sat <= err_sat_d;
            end
        end
    end

    // ---------------- stage 2: P, I, D and integrator update ----------------
    logic signed [INT_W-1:0] integrator;
    logic signed [IS_W-1:0]  int_sum;
    logic                    int_ovf;
    logic signed [INT_W-1:0] int_next;
    logic signed [P_W-1:0]   p_prod;
    logic signed [I_W-1:0]   i_cur;
    logic signed [P_W-1:0]   p_term;
    logic signed [I_W-1:0]   i_term;
    logic signed [D_W-1:0]   d_term;
    logic [FRWRD_W-1:0]      frwrd_q;
    logic                    v2;

    always_comb begin
        // One extra bit detects overflow: top two bits of the sum disagree.
        int_sum  = IS_W'(integrator) + IS_W'(err_sat);
        int_ovf  = int_sum[INT_W] != int_sum[INT_W-1];
        int_next = int_sum[INT_W-1:0];
        if (int_ovf) begin
            if (INT_CLAMP != 0) begin
                int_next = int_sum[INT_W] ? INT_MIN : INT_MAX;
            end else begin
                int_next = integrator;
            end
        end
        p_prod = P_W'(err_sat) * P_W'($signed({1'b0, kp}));
        // I term uses the integrator value before this sample's update.
        i_cur  = I_W'(integrator >>> I_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integrator <= '0;
            p_term     <= '0;
            i_term     <= '0;
            frwrd_q    <= '0;
            v2         <= 1'b0;
        end else if (!moving) begin
            integrator <= '0;
            p_term     <= '0;
            i_term     <= '0;
            frwrd_q    <= '0;
            v2         <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                integrator <= int_next;
                p_term     <= p_prod;
                i_term     <= i_cur;
                frwrd_q    <= frwrd;
            end
        end
    end

    pid_deriv #(
        .SAT_W   (SAT_W),
        .D_DEPTH (D_DEPTH),
        .D_W     (D_W)
    ) u_deriv (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!moving),
        .en      (v1),
        .err_sat (err_sat),
        .kd      (kd),
        .d_term  (d_term)
    );

    // ---------------- stage 3: PID sum and wheel speeds ----------------
    logic signed [SUM_W-1:0] pid_sum;
    logic signed [PID_W-1:0] pid;
    logic signed [31:0]      pid_adj;
    logic signed [31:0]      fw_ext;
    logic signed [SPD_W-1:0] lft_d;
    logic signed [SPD_W-1:0] rght_d;

    always_comb begin
        pid_sum = SUM_W'(p_term) + SUM_W'(i_term) + SUM_W'(d_term);
        pid     = PID_W'(sat_signed(32'(pid_sum), SUM_W, PID_W));
        pid_adj = 32'(pid >>> 3);
        fw_ext  = $signed(32'(frwrd_q));
        lft_d   = SPD_W'(sat_signed(fw_ext + pid_adj, 32, SPD_W));
        rght_d  = SPD_W'(sat_signed(fw_ext - pid_adj, 32, SPD_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else if (!moving) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else begin
            spd_vld <= v2;
            if (v2) begin
                lft_spd  <= lft_d;
                rght_spd <= rght_d;
            end
        end
    end

endmodule

// File: tb/tb_pid_ctrl_param.sv
// tb_pid_ctrl_param: bench for pid_ctrl_param. Two instances share stimulus,
// one with a clamping integrator and one with a skip-on-overflow integrator.
// A reference model computes each sample's wheel speeds with integer arithmetic
// and queues them; every cycle the DUT outputs are compared with the model.
module tb_pid_ctrl_param;
    import pid_pkg::*;

    localparam int SAT_W   = 10;
    localparam int SPD_W   = 11;
    localparam int I_SHIFT = 6;
    localparam int D_DEPTH = 3;
    localparam int PID_W   = 14;
    localparam int IMAX    = 16383;
    localparam int IMIN    = -16384;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    moving;
    logic                    err_vld;
    logic signed [11:0]      error;
    logic [9:0]              frwrd;
    logic [4:0]              kp;
    logic [4:0]              kd;
    logic signed [SPD_W-1:0] lft_c, rght_c, lft_n, rght_n;
    logic                    vld_c, vld_n;

    pid_ctrl_param #(.INT_CLAMP(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .moving(moving), .err_vld(err_vld), .error(error),
        .frwrd(frwrd), .kp(kp), .kd(kd),
        .lft_spd(lft_c), .rght_spd(rght_c), .spd_vld(vld_c)
    );

    pid_ctrl_param #(.INT_CLAMP(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .moving(moving), .err_vld(err_vld), .error(error),
        .frwrd(frwrd), .kp(kp), .kd(kd),
        .lft_spd(lft_n), .rght_spd(rght_n), .spd_vld(vld_n)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int  m_integ [2];          // [0] clamping, [1] skip-on-overflow
    int  m_hist_q[$];          // last D_DEPTH saturated errors, oldest first
    bit  m_s1_vld;
    int  m_s1_err;
    int  m_lft [2];
    int  m_rght[2];
    bit  m_vld;
    logic [4*SPD_W-1:0] exp_q[$];

    function automatic int sat(int v, int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_reset();
        m_integ[0] = 0;
        m_integ[1] = 0;
        m_hist_q.delete();
        for (int k = 0; k < D_DEPTH; k++) m_hist_q.push_back(0);
        m_s1_vld = 0;
        m_s1_err = 0;
        m_lft[0] = 0; m_lft[1] = 0;
        m_rght[0] = 0; m_rght[1] = 0;
        m_vld = 0;
        exp_q.delete();
    endtask

    // One clock edge of the model, given the inputs the DUT saw at that edge.
    task automatic model_edge(bit mv, bit ev, int er, int kpv, int kdv, int fw);
        logic [4*SPD_W-1:0] e_pk;
        int e, p, d, i, pid, lft, rght, n, old;
        int r_l[2];
        int r_r[2];
        if (!mv) begin
            model_reset();
            return;
        end
        m_vld = 0;
        if (exp_q.size() > 0) begin
            e_pk = exp_q.pop_front();
            m_lft[0]  = int'($signed(e_pk[4*SPD_W-1:3*SPD_W]));
            m_rght[0] = int'($signed(e_pk[3*SPD_W-1:2*SPD_W]));
            m_lft[1]  = int'($signed(e_pk[2*SPD_W-1:SPD_W]));
            m_rght[1] = int'($signed(e_pk[SPD_W-1:0]));
            m_vld = 1;
        end
        if (m_s1_vld) begin
            e   = m_s1_err;
            old = m_hist_q.pop_front();
            m_hist_q.push_back(e);
            p = e * kpv;
            d = sat(e - old, SAT_W - 2) * kdv;
            for (int m = 0; m < 2; m++) begin
                i    = m_integ[m] >>> I_SHIFT;
                pid  = sat(p + i + d, PID_W);
                lft  = sat(fw + (pid >>> 3), SPD_W);
                rght = sat(fw - (pid >>> 3), SPD_W);
                r_l[m] = lft;
                r_r[m] = rght;
                n = m_integ[m] + e;
                if (n > IMAX || n < IMIN) begin
                    if (m == 0) m_integ[m] = (n > IMAX) ? IMAX : IMIN;
                end else begin
                    m_integ[m] = n;
                end
            end
            exp_q.push_back({SPD_W'(r_l[0]), SPD_W'(r_r[0]), SPD_W'(r_l[1]), SPD_W'(r_r[1])});
        end
        m_s1_vld = ev;
        if (ev) m_s1_err = sat(er, SAT_W);
    endtask

    // ---------------- checking ----------------
    task automatic check(string tag, logic signed [31:0] got, logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("vld_c",  vld_c,  m_vld);
        check("lft_c",  lft_c,  m_lft[0]);
        check("rght_c", rght_c, m_rght[0]);
        check("vld_n",  vld_n,  m_vld);
        check("lft_n",  lft_n,  m_lft[1]);
        check("rght_n", rght_n, m_rght[1]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        bit mv, ev;
        int er, kpv, kdv, fw;
        mv = moving; ev = err_vld; er = int'(error);
        kpv = int'(kp); kdv = int'(kd); fw = int'(frwrd);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(mv, ev, er, kpv, kdv, fw);
        #1;
        check_outputs();
    endtask

    // One isolated strobe; on return its pulse is on the outputs.
    task automatic send(int val);
        err_vld = 1'b1;
        error   = 12'(val);
        step();
        err_vld = 1'b0;
        step();
        step();
    endtask

    task automatic clear_pipe();
        moving  = 1'b0;
        err_vld = 1'b0;
        step();
        moving = 1'b1;
    endtask

    int der_exp[4] = '{243, 243, 243, 200};

    // ---------------- stimulus ----------------
    initial begin
        moving = 1'b0; err_vld = 1'b0; error = '0; frwrd = '0; kp = '0; kd = '0;
        model_reset();

        // Reset state
        step();
        step();
        check("reset_lft", lft_c, 0);
        check("reset_vld", vld_c, 0);
        @(negedge clk);
        rst_n = 1'b1;
        moving = 1'b1;
        step();

        // Basic
        kp = 5'(KP_LEGACY); kd = 5'd0; frwrd = 10'd200;
        clear_pipe();
        send(100);
        check("basic_vld", vld_c, 1);
        check("basic_lft", lft_c, 300);
        check("basic_rght", rght_c, 100);
        step();
        check("basic_pulse_width", vld_c, 0);
        check("basic_hold", lft_c, 300);

        // Error saturation
        clear_pipe();
        frwrd = 10'd0;
        send(12'h7FF);
        check("errsat_lft", lft_c, 511);
        check("errsat_rght", rght_c, -511);

        // Integrator
        clear_pipe();
        kp = 5'd0; frwrd = 10'd200;
        for (int k = 0; k < 64; k++) send(64);
        send(64);
        check("integ_lft", lft_c, 208);
        check("integ_rght", rght_c, 192);

        // Anti-windup
        clear_pipe();
        for (int k = 0; k < 40; k++) send(511);
        check("aw_integ_c", dut_c.integrator, 16383);
        check("aw_integ_n", dut_n.integrator, 16352);
        check("aw_lft_c", lft_c, 231);
        check("aw_lft_n", lft_n, 231);
        send(-511);
        send(-511);
        check("aw_back_lft_c", lft_c, 231);
        check("aw_back_lft_n", lft_n, 230);

        // Derivative
        clear_pipe();
        kd = 5'(KD_LEGACY); kp = 5'd0;
        for (int k = 0; k < 4; k++) send(0);
        for (int k = 0; k < 4; k++) begin
            send(50);
            check($sformatf("deriv_lft_%0d", k), lft_c, der_exp[k]);
        end

        // Clear mid-stream
        kp = 5'd8; kd = 5'd0;
        for (int k = 0; k < 5; k++) begin
            err_vld = 1'b1;
            error = 12'($urandom_range(0, 400)) - 12'sd200;
            step();
        end
        moving = 1'b0;
        step();
        check("clr_vld", vld_c, 0);
        check("clr_lft", lft_c, 0);
        check("clr_rght", rght_n, 0);
        check("clr_integ_c", dut_c.integrator, 0);
        check("clr_integ_n", dut_n.integrator, 0);
        moving = 1'b1; err_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("clr_no_pulse", vld_c, 0);
        end

        // Output saturation
        frwrd = 10'd1023; kp = 5'd31; kd = 5'd0;
        send(511);
        check("osat_lft", lft_c, 1023);
        check("osat_rght", rght_c, 0);

        // Randomised stream: back-to-back strobes, gain changes, clears
        for (int k = 0; k < 800; k++) begin
            moving  = ($urandom_range(0, 39) != 0);
            err_vld = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) error = 12'($urandom);
            else error = 12'($urandom_range(0, 300)) - 12'sd150;
            kp    = 5'($urandom);
            kd    = 5'($urandom);
            frwrd = 10'($urandom);
            step();
        end

        // Asynchronous reset mid-pipeline
        moving = 1'b1; kp = 5'd8; frwrd = 10'd300;
        for (int k = 0; k < 4; k++) begin
            err_vld = 1'b1;
            error = 12'($urandom_range(0, 200));
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_vld", vld_c, 0);
        check("arst_lft", lft_c, 0);
        check("arst_rght", rght_n, 0);
        check("arst_integ", dut_c.integrator, 0);
        err_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_ctrl_param.md
# pid_ctrl_param

Parametrised, pipelined PID heading controller: the successor to the fixed-gain PID. Sits between the error source (IR/gyro heading error, `err_vld` strobe) and the motor drive, and produces saturated left/right wheel speeds. It adds:
- runtime-programmable P and D gains;
- a configurable derivative history depth;
- a selectable integrator anti-windup mode;
- two-sided output saturation;
- an explicit output-valid strobe.

## Interface
Parameters:
- `ERR_W`, 12: raw error width (signed).
- `SAT_W`, 10: saturated error width (signed).
- `FRWRD_W`, 10: forward speed width (unsigned).
- `SPD_W`, 11: output speed width (signed).
- `INT_W`, 15: integrator width (signed).
- `I_SHIFT`, 6: integrator-to-I_term right shift.
- `D_DEPTH`, 3: derivative lag in valid samples (1..8).
- `PID_W`, 14: PID sum width after saturation.
- `INT_CLAMP`, 1: 1 = integrator saturates at rails; 0 = update skipped on overflow.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `moving`, in, 1: 0 clears the integrator, the derivative history and the outputs.
- `err_vld`, in, 1: single-cycle strobe, `error` valid.
- `error`, in, `ERR_W`: signed heading error.
- `frwrd`, in, `FRWRD_W`: unsigned forward speed.
- `kp`, in, 5: unsigned P gain; 8 reproduces the legacy scaling.
- `kd`, in, 5: unsigned D gain; 7 reproduces the legacy scaling.
- `lft_spd`, out, `SPD_W`: signed left speed. Reset 0.
- `rght_spd`, out, `SPD_W`: signed right speed. Reset 0.
- `spd_vld`, out, 1: pulses when the speeds update. Reset 0.

## Operation
- **S1** (on `err_vld`): register `err_sat` and `v1`. `err_sat` is `error` saturated to `SAT_W`, range −512..511 at default widths.
- **S2** (on `v1`): compute P, D and the integrator update.
  - P = `err_sat` × `kp` (signed × unsigned).
  - D: `diff` = `err_sat` − `hist[D_DEPTH-1]`, saturated to `SAT_W`−2 bits (−128..127), then × `kd`.
  - `hist` is a shift register, updated with `err_sat` on `v1`.
  - I = `integrator` >>> `I_SHIFT`, taken from the value before this update.
  - Integrator: `integrator` += sign-extended `err_sat`. On overflow with `INT_CLAMP`=1 it holds the rail (+2^(INT_W−1)−1 or −2^(INT_W−1)); with `INT_CLAMP`=0 the integrator is unchanged.
  - Register P, I, D, `frwrd` and `v2`.
- **S3** (on `v2`): `pid` = sat_`PID_W`(P + I + D), with the sum computed at `PID_W`+2 bits; register `v3`.
  - `lft` = `frwrd` + (`pid` >>> 3); `rght` = `frwrd` − (`pid` >>> 3).
  - Both are saturated to the signed `SPD_W` range (−1024..1023).
  - Register the results into `lft_spd`/`rght_spd`; `spd_vld` = `v3`.
- **`moving`=0** (any cycle): next edge clears the integrator, `hist`, `v1`..`v3` and the outputs, so speeds are 0 and `spd_vld` is 0. Strobes in flight are discarded.
- **Gains**: `kp`/`kd` are sampled in S2; a gain change affects only samples entering S2 after the change.

## Timing
- Latency: `err_vld` at cycle n gives `spd_vld` and new speeds at n+3. Throughput: one sample per cycle.
- Outputs hold their value between `spd_vld` pulses.
- Back-to-back strobes: each produces its own pulse, in order, three cycles later.
- `moving` falling edge together with `err_vld`: the clear wins, no output pulse.
- Reset mid-pipeline: all state returns to 0 asynchronously.

## Structure
- Package `pid_pkg`:
  - default width constants;
  - `sat_signed` function (in width, out width);
  - legacy gain constants `KP_LEGACY`=8 and `KD_LEGACY`=7.
- Sub-module `pid_deriv`: history shift register of depth `D_DEPTH`, difference, saturation and the `kd` multiply (covers the D part of S2).
- Everything else is in the top level.

## Test plan
All cases use `kd`=0 and `frwrd`=200 unless stated; `moving`=1 unless stated.
- **Basic**: `kp`=8, single `err_vld`, `error`=100. Pulse at +3 cycles: `lft_spd`=300, `rght_spd`=100.
- **Error saturation**: `error`=12'h7FF, `kp`=8, `frwrd`=0. `err_sat`=511, `pid`=4088, `lft_spd`=511, `rght_spd`=−511.
- **Integrator**: `kp`=0, 64 strobes of `error`=64. The integrator reaches 4096, so the 65th strobe gives I=64, `lft_spd`=208.
- **Anti-windup**: `kp`=0, continuous `error`=511.
  - `INT_CLAMP`=1: the integrator sticks at 16383 and I=255.
  - `INT_CLAMP`=0: the integrator stops at its last non-overflowing value, 16352.
- **Derivative**: `kd`=7, `kp`=0, `D_DEPTH`=3, `error` steps 0→50. The next three pulses have D=350; D returns to 0 from the fourth.
- **Clear and output saturation**:
  - Drop `moving` mid-stream: outputs are 0 next cycle, no pulse, integrator 0.
  - `frwrd`=1023, `kp`=31, `error`=511: `lft_spd`=1023 (saturated).
